// File: rtl/dehaze_pkg.sv
// Shared constants for the dehazing filter front end.
// Border modes, tap limits and pointer-width helper.
package dehaze_pkg;

    localparam int PIX_W_DEF = 24;
    localparam int MAX_TAPS = 8;

    localparam logic BORDER_REPLICATE = 1'b0;
    localparam logic BORDER_ZERO = 1'b1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_tap_select.sv
// Border correction for a horizontal tap window.
// Taps past the row end are replaced by the last pixel or by zero.
module line_tap_select
    import dehaze_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ROW_SIZE = 512,
    parameter int TAPS = 3,
    parameter int COL_W = ptr_w(ROW_SIZE)
) (
    input  logic [COL_W-1:0]      col,
    input  logic [TAPS*PIX_W-1:0] raw,
    input  logic                  border_zero,
    output logic [TAPS*PIX_W-1:0] window
);

    int last;

    // last = tap index holding column ROW_SIZE-1 (only used past the edge)
    always_comb begin
        window = '0;
        last = ROW_SIZE - 1 - int'(col);
        for (int k = 0; k < TAPS; k++) begin
            if (int'(col) + k <= ROW_SIZE - 1) begin
                window[(TAPS-1-k)*PIX_W +: PIX_W] =
                    raw[(TAPS-1-k)*PIX_W +: PIX_W];
            end else if (border_zero == BORDER_REPLICATE) begin
                window[(TAPS-1-k)*PIX_W +: PIX_W] =
                    raw[(TAPS-1-last)*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/line_tap_buffer.sv
// Single-row pixel buffer emitting TAPS-wide windows with
// ready/valid flow control and selectable right-edge handling.
module line_tap_buffer
    import dehaze_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ROW_SIZE = 512,
    parameter int TAPS = 3,
    localparam int COL_W = ptr_w(ROW_SIZE),
    localparam int LVL_W = ptr_w(ROW_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  border_zero,
    input  logic [PIX_W-1:0]      in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [TAPS*PIX_W-1:0] out_window,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [COL_W-1:0]      out_col,
    output logic [LVL_W-1:0]      level
);

    logic [PIX_W-1:0]      mem [ROW_SIZE];
    logic [COL_W-1:0]      wr_ptr;
    logic [COL_W-1:0]      rd_ptr;
    logic [TAPS*PIX_W-1:0] raw;
    logic [TAPS*PIX_W-1:0] window;
    logic [LVL_W-1:0]      rem;
    logic [LVL_W-1:0]      avail;
    logic                  can_adv;
    logic                  adv;
    logic                  wr_en;

    function automatic logic [COL_W-1:0] inc(input logic [COL_W-1:0] p);
        return (p == COL_W'(ROW_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads wrap so the address stays legal; taps past the edge are fixed up later
    always_comb begin
        raw = '0;
        for (int k = 0; k < TAPS; k++) begin
            raw[(TAPS-1-k)*PIX_W +: PIX_W] =
                mem[COL_W'((int'(rd_ptr) + k) % ROW_SIZE)];
        end
    end

    always_comb begin
        rem = LVL_W'(ROW_SIZE) - LVL_W'(rd_ptr);
        avail = (rem < LVL_W'(TAPS)) ? rem : LVL_W'(TAPS);
    end

    assign can_adv = (level >= avail);
    assign in_ready = (level != LVL_W'(ROW_SIZE));
    assign wr_en = in_valid && in_ready;
    assign adv = (!out_valid || out_ready) && can_adv;

    line_tap_select #(
        .PIX_W    (PIX_W),
        .ROW_SIZE (ROW_SIZE),
        .TAPS     (TAPS),
        .COL_W    (COL_W)
    ) u_select (
        .col         (rd_ptr),
        .raw         (raw),
        .border_zero (border_zero),
        .window      (window)
    );

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_window <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_window <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (adv) begin
                rd_ptr     <= inc(rd_ptr);
                out_window <= window;
                out_col    <= rd_ptr;
                out_last   <= (rd_ptr == COL_W'(ROW_SIZE - 1));
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            level <= level + LVL_W'(wr_en) - LVL_W'(adv);
        end
    end

endmodule
